// File: rtl/ps2_command_sequencer_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : ps2_command_sequencer_pkg                                    |
// | Purpose : Shared constants for the PS/2 host-to-device command engine: |
// |           FSM state encoding, device response bytes, status bit        |
// |           positions and the transmit-bit selection helper.             |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
package ps2_command_sequencer_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_INHIBIT   = 3'd1;
  localparam logic [2:0] ST_REQUEST   = 3'd2;
  localparam logic [2:0] ST_SEND      = 3'd3;
  localparam logic [2:0] ST_LINE_ACK  = 3'd4;
  localparam logic [2:0] ST_WAIT_RESP = 3'd5;
  localparam logic [2:0] ST_DONE      = 3'd6;
  localparam logic [2:0] ST_FAIL      = 3'd7;

  localparam logic [7:0] PS2_ACK    = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;

  localparam int STAT_DONE  = 0;
  localparam int STAT_IE    = 1;
  localparam int STAT_BUSY  = 2;
  localparam int STAT_ERROR = 3;

  // Index 0..7 are data bits, 8 is the parity bit; the stop bit is a release.
  localparam logic [3:0] LAST_TX_BIT = 4'd8;

  function automatic logic tx_bit(input logic [7:0] cmd, input logic [3:0] idx);
    if (idx < LAST_TX_BIT) return cmd[idx[2:0]];
    return ~^cmd;  // odd parity
  endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_command_sequencer_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : ps2_command_sequencer_if                                   |
// | Purpose   : ECO32-style register bus to the PS/2 command engine.       |
// |   bus_enable/bus_write/bus_address/bus_write_data : master -> slave    |
// |   bus_read_data/bus_wait                           : slave -> master   |
// | Rev       : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface ps2_command_sequencer_if;
  logic       bus_enable;
  logic       bus_write;
  logic       bus_address;
  logic [7:0] bus_write_data;
  logic [7:0] bus_read_data;
  logic       bus_wait;

  modport master (
    output bus_enable, bus_write, bus_address, bus_write_data,
    input  bus_read_data, bus_wait
  );

  modport slave (
    input  bus_enable, bus_write, bus_address, bus_write_data,
    output bus_read_data, bus_wait
  );
endinterface
`default_nettype wire

// File: rtl/ps2_command_sequencer_line_sync.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ps2_line_sync                                                |
// | Purpose : Two-flop synchronizers for the raw PS/2 clock and data lines |
// |           plus a one-cycle pulse on each synchronized clock fall.      |
// | Ports   : clk, rst_n          system clock, async active-low reset     |
// |           i_ps2_clock/data    raw open-drain lines                     |
// |           o_clk_fall          pulse on synced clock 1->0               |
// |           o_data_sync         synchronized data line                   |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ps2_clock,
  input  logic i_ps2_data,
  output logic o_clk_fall,
  output logic o_data_sync
);

  // [1] is the synchronized clock, [2] its previous value for edge detection.
  logic [2:0] r_clk_pipe;
  logic [1:0] r_data_pipe;

  // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_pipe  <= 3'b111;
      r_data_pipe <= 2'b11;
    end else begin
      r_clk_pipe  <= {r_clk_pipe[1:0], i_ps2_clock};
      r_data_pipe <= {r_data_pipe[0], i_ps2_data};
    end
  end

  assign o_clk_fall  = r_clk_pipe[2] & ~r_clk_pipe[1];
  assign o_data_sync = r_data_pipe[1];

endmodule
`default_nettype wire

// File: rtl/ps2_command_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : ps2_command_sequencer                                        |
// | Purpose : Sends one CPU-written command byte to a PS/2 device (inhibit,|
// |           start, 8 data, odd parity, stop), checks the line-ack and    |
// |           waits for the ACK/RESEND response with retries and timeout.  |
// | Ports   : clk, rst_n             clock, async active-low reset         |
// |           bus                    register bus (slave modport)          |
// |           o_interrupt            done & interrupt enable               |
// |           i_ps2_clock/i_ps2_data raw PS/2 lines                        |
// |           o_ps2_*_drive_low      open-drain pull-downs                 |
// |           i_rx_data_ready/i_rx_data  byte from the receive path        |
// |           o_rx_swallow           receive path must not post to CPU     |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module ps2_command_sequencer
  import ps2_command_sequencer_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic                          clk,
  input  logic                          rst_n,
  ps2_command_sequencer_if.slave        bus,
  output logic                          o_interrupt,
  input  logic                          i_ps2_clock,
  input  logic                          i_ps2_data,
  output logic                          o_ps2_clock_drive_low,
  output logic                          o_ps2_data_drive_low,
  input  logic                          i_rx_data_ready,
  input  logic [7:0]                    i_rx_data,
  output logic                          o_rx_swallow
);

  localparam int c_inh_w = $clog2(INHIBIT_CYCLES + 1);
  localparam int c_tmo_w = $clog2(TIMEOUT_CYCLES + 1);
  localparam int c_rty_w = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam logic [c_inh_w-1:0] c_inh_last = c_inh_w'(INHIBIT_CYCLES - 1);
  localparam logic [c_tmo_w-1:0] c_tmo_max  = c_tmo_w'(TIMEOUT_CYCLES);
  localparam logic [c_rty_w-1:0] c_rty_max  = c_rty_w'(MAX_RETRIES);

  logic [2:0]         r_state;
  logic [7:0]         r_cmd;
  logic               r_done;
  logic               r_error;
  logic               r_ie;
  logic [c_rty_w-1:0] r_retry;
  logic [c_tmo_w-1:0] r_timer;
  logic [c_inh_w-1:0] r_inh_cnt;
  logic [3:0]         r_bit_idx;
  logic               r_clk_dl;
  logic               r_data_dl;

  logic       w_clk_fall;
  logic       w_data_sync;
  logic       w_wr_ctrl;
  logic       w_wr_cmd;
  logic       w_accept;
  logic       w_busy;
  logic       w_timeout;
  logic       w_retry_inc;
  logic [2:0] w_state_next;
  logic [3:0] w_bit_next;
  logic       w_data_dl_next;
  logic [7:0] w_status;

  ps2_line_sync u_line_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ps2_clock (i_ps2_clock),
    .i_ps2_data  (i_ps2_data),
    .o_clk_fall  (w_clk_fall),
    .o_data_sync (w_data_sync)
  );

  assign w_wr_ctrl = bus.bus_enable & bus.bus_write & ~bus.bus_address;
  assign w_wr_cmd  = bus.bus_enable & bus.bus_write &  bus.bus_address;
  assign w_busy    = (r_state != ST_IDLE);
  assign w_accept  = w_wr_cmd & ~w_busy;
  // DONE/FAIL last a single cycle and already head for IDLE.
  assign w_timeout = w_busy && (r_state != ST_DONE) && (r_state != ST_FAIL)
                     && (r_timer == c_tmo_max);

  always_comb begin
    w_state_next = r_state;
    w_bit_next   = r_bit_idx;
    w_retry_inc  = 1'b0;
    case (r_state)
      ST_IDLE:      if (w_accept) w_state_next = ST_INHIBIT;
      ST_INHIBIT:   if (r_inh_cnt == c_inh_last) w_state_next = ST_REQUEST;
      ST_REQUEST:   if (w_clk_fall) begin
                      w_state_next = ST_SEND;
                      w_bit_next   = 4'd0;
                    end
      // The fall that leaves the parity bit presents the stop bit (a release).
      ST_SEND:      if (w_clk_fall) begin
                      if (r_bit_idx == LAST_TX_BIT) w_state_next = ST_LINE_ACK;
                      else                          w_bit_next   = r_bit_idx + 4'd1;
                    end
      ST_LINE_ACK:  if (w_clk_fall) w_state_next = w_data_sync ? ST_FAIL : ST_WAIT_RESP;
      ST_WAIT_RESP: if (i_rx_data_ready) begin
                      if (i_rx_data == PS2_ACK) begin
                        w_state_next = ST_DONE;
                      end else if (i_rx_data == PS2_RESEND && r_retry != c_rty_max) begin
                        w_state_next = ST_INHIBIT;
                        w_retry_inc  = 1'b1;
                      end else begin
                        w_state_next = ST_FAIL;
                      end
                    end
      ST_DONE:      w_state_next = ST_IDLE;
      ST_FAIL:      w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = ST_FAIL;
      w_retry_inc  = 1'b0;
    end
  end

  // Drive-lows are decoded from the next state and registered so they can
  // never glitch.
  always_comb begin
    w_data_dl_next = 1'b0;
    case (w_state_next)
      ST_REQUEST: w_data_dl_next = 1'b1;
      ST_SEND:    w_data_dl_next = ~tx_bit(r_cmd, w_bit_next);
      default:    w_data_dl_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cmd     <= 8'h00;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_ie      <= 1'b0;
      r_retry   <= '0;
      r_timer   <= '0;
      r_inh_cnt <= '0;
      r_bit_idx <= 4'd0;
      r_clk_dl  <= 1'b0;
      r_data_dl <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_bit_idx <= w_bit_next;
      r_clk_dl  <= (w_state_next == ST_INHIBIT);
      r_data_dl <= w_data_dl_next;

      if (r_state != ST_INHIBIT)       r_inh_cnt <= '0;
      else if (r_inh_cnt != c_inh_last) r_inh_cnt <= r_inh_cnt + c_inh_w'(1);

      if (!w_busy || w_retry_inc)   r_timer <= '0;
      else if (r_timer != c_tmo_max) r_timer <= r_timer + c_tmo_w'(1);

      if (w_accept) begin
        r_cmd   <= bus.bus_write_data;
        r_retry <= '0;
      end else if (w_retry_inc) begin
        r_retry <= r_retry + c_rty_w'(1);
      end

      // Hardware completion wins over a same-cycle software write of done.
      if (r_state == ST_DONE || r_state == ST_FAIL) r_done <= 1'b1;
      else if (w_accept)                             r_done <= 1'b0;
      else if (w_wr_ctrl)                            r_done <= bus.bus_write_data[0];

      if (w_wr_ctrl) r_ie <= bus.bus_write_data[1];

      if (r_state == ST_FAIL) r_error <= 1'b1;
      else if (w_accept)      r_error <= 1'b0;
    end
  end

  always_comb begin
    w_status             = 8'h00;
    w_status[STAT_DONE]  = r_done;
    w_status[STAT_IE]    = r_ie;
    w_status[STAT_BUSY]  = w_busy;
    w_status[STAT_ERROR] = r_error;
    bus.bus_read_data    = bus.bus_address ? r_cmd : w_status;
  end

  assign bus.bus_wait              = 1'b0;
  assign o_interrupt               = r_done & r_ie;
  assign o_ps2_clock_drive_low     = r_clk_dl;
  assign o_ps2_data_drive_low      = r_data_dl;
  assign o_rx_swallow              = (r_state == ST_WAIT_RESP);

endmodule
`default_nettype wire

// File: tb/tb_ps2_command_sequencer.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_ps2_command_sequencer                                     |
// | Purpose : Self-checking bench with a PS/2 device model: frame capture, |
// |           line-ack, ACK/RESEND responses, timeout and reset recovery.  |
// | Rev     : 1.0  initial release                                         |
// +------------------------------------------------------------------------+
module tb_ps2_command_sequencer;

  localparam int INH  = 20;
  localparam int TMO  = 600;
  localparam int MAXR = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       interrupt, clk_dl, data_dl, swallow;
  logic       rx_ready = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clock_line, ps2_data_line;

  int n_vec = 0;
  int n_miss = 0;
  int swallow_cycles = 0;
  int cyc = 0;
  logic ie_model = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (swallow) swallow_cycles <= swallow_cycles + 1;

  // Open-drain wired-AND of host and device pull-downs.
  assign ps2_clock_line = ~(dev_clk_low | clk_dl);
  assign ps2_data_line  = ~(dev_data_low | data_dl);

  ps2_command_sequencer_if bus_if ();

  ps2_command_sequencer #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRIES    (MAXR)
  ) dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .bus                   (bus_if.slave),
    .o_interrupt           (interrupt),
    .i_ps2_clock           (ps2_clock_line),
    .i_ps2_data            (ps2_data_line),
    .o_ps2_clock_drive_low (clk_dl),
    .o_ps2_data_drive_low  (data_dl),
    .i_rx_data_ready       (rx_ready),
    .i_rx_data             (rx_data),
    .o_rx_swallow          (swallow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Host drive-low pattern the device sees before each of the 11 falls:
  // start (pulled), data LSB first (pulled when 0), odd parity, stop (released).
  function automatic logic [10:0] expect_frame(input logic [7:0] c);
    logic [10:0] v;
    logic        par;
    par  = ($countones(c) % 2) == 0;
    v[0] = 1'b1;
    for (int i = 0; i < 8; i++) v[i+1] = ~c[i];
    v[9]  = ~par;
    v[10] = 1'b0;
    return v;
  endfunction

  task automatic bus_write(input logic a, input logic [7:0] d);
    @(negedge clk);
    bus_if.bus_enable = 1'b1; bus_if.bus_write = 1'b1;
    bus_if.bus_address = a;   bus_if.bus_write_data = d;
    @(negedge clk);
    bus_if.bus_enable = 1'b0; bus_if.bus_write = 1'b0;
  endtask

  task automatic bus_read(input logic a, output logic [7:0] d);
    @(negedge clk);
    bus_if.bus_enable = 1'b1; bus_if.bus_write = 1'b0; bus_if.bus_address = a;
    #1 d = bus_if.bus_read_data;
    bus_if.bus_enable = 1'b0;
  endtask

  // Device side of one attempt: measure the inhibit, then clock n_falls edges
  // sampling the host drive-low before each fall; optionally line-ack.
  task automatic device_frame(input int half, input bit ack, input int n_falls,
                              output logic [10:0] seen, output int inh_len, output bit ok);
    int budget;
    ok = 1'b1; seen = '0; inh_len = 0; budget = 0;
    while (!clk_dl && budget < 4*TMO) begin @(negedge clk); budget++; end
    if (!clk_dl) begin ok = 1'b0; return; end
    while (clk_dl && inh_len < 4*TMO) begin @(negedge clk); inh_len++; end
    for (int k = 0; k < n_falls; k++) begin
      repeat (half) @(negedge clk);
      seen[k] = data_dl;
      if (k == 10 && ack) dev_data_low = 1'b1;
      repeat (4) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (half) @(negedge clk);
      dev_clk_low = 1'b0;
    end
    repeat (2) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  task automatic device_respond(input logic [7:0] b);
    repeat (3) @(negedge clk);
    rx_data = b; rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic run_cmd(input logic [7:0] c, input int n_resend, input bit line_ack, input int half);
    logic [10:0] seen;
    logic [7:0]  st;
    int          inh, phases, sw0;
    bit          ok, exp_err;
    exp_err = !line_ack || (n_resend > MAXR);
    phases  = !line_ack ? 1 : ((n_resend > MAXR) ? MAXR + 1 : n_resend + 1);
    sw0 = swallow_cycles;
    bus_write(1'b1, c);
    for (int p = 0; p < phases; p++) begin
      device_frame(half, line_ack, 11, seen, inh, ok);
      check("frame_started", 32'(ok), 32'd1);
      if (!ok) return;
      check("inhibit_len", inh, INH);
      check("frame_bits", 32'(seen), 32'(expect_frame(c)));
      if (line_ack) begin
        check("rx_swallow", 32'(swallow), 32'd1);
        device_respond((p < n_resend) ? 8'hFE : 8'hFA);
      end
    end
    repeat (5) @(negedge clk);
    bus_read(1'b0, st);
    check("status", 32'(st), 32'({4'b0, exp_err, 1'b0, ie_model, 1'b1}));
    check("lines_released", 32'({clk_dl, data_dl}), 32'd0);
    if (!line_ack) check("no_swallow", swallow_cycles - sw0, 0);
  endtask

  initial begin
    logic [7:0]  rd;
    logic [10:0] seen;
    int          inh, t0, t1;
    bit          ok;
    bus_if.bus_enable = 1'b0; bus_if.bus_write = 1'b0;
    bus_if.bus_address = 1'b0; bus_if.bus_write_data = 8'h00;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_drive_lows", 32'({clk_dl, data_dl}), 32'd0);
    check("rst_irq", 32'(interrupt), 32'd0);
    check("rst_swallow", 32'(swallow), 32'd0);
    bus_read(1'b0, rd);
    check("rst_status", 32'(rd), 32'h00);
    check("bus_wait", 32'(bus_if.bus_wait), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // 0xED with interrupts enabled, immediate ACK
    bus_write(1'b0, 8'h02); ie_model = 1'b1;
    run_cmd(8'hED, 0, 1'b1, 8);
    check("irq_set", 32'(interrupt), 32'd1);
    bus_read(1'b1, rd);
    check("cmd_readback", 32'(rd), 32'hED);
    bus_write(1'b0, 8'h02);
    #1 check("irq_cleared", 32'(interrupt), 32'd0);
    bus_read(1'b0, rd);
    check("status_after_clear", 32'(rd), 32'h02);

    // RESEND twice then ACK; RESEND beyond the retry limit
    run_cmd(8'h3C, 2, 1'b1, 7);
    run_cmd(8'hF4, 4, 1'b1, 9);
    check("irq_on_error", 32'(interrupt), 32'd1);
    bus_write(1'b0, 8'h00); ie_model = 1'b0;

    // Device never clocks: timeout, busy writes ignored
    bus_write(1'b1, 8'h5A);
    t0 = cyc;
    repeat (INH + 5) @(negedge clk);
    check("request_start_bit", 32'({clk_dl, data_dl}), 32'b01);
    bus_write(1'b1, 8'h20);
    bus_read(1'b1, rd);
    check("busy_write_ignored", 32'(rd), 32'h5A);
    bus_read(1'b0, rd);
    check("busy_status", 32'(rd), 32'h04);
    while (data_dl && (cyc - t0) < 2*TMO) @(negedge clk);
    t1 = cyc;
    check("timeout_window", 32'((t1 - t0) >= TMO && (t1 - t0) <= TMO + 3), 32'd1);
    repeat (3) @(negedge clk);
    bus_read(1'b0, rd);
    check("timeout_status", 32'(rd), 32'h09);
    check("timeout_released", 32'({clk_dl, data_dl}), 32'd0);

    // Missing line-ack
    run_cmd(8'h55, 0, 1'b0, 8);

    // Reset in the middle of a frame, then a clean command
    bus_write(1'b1, 8'hA5);
    device_frame(8, 1'b0, 4, seen, inh, ok);
    check("partial_started", 32'(ok), 32'd1);
    @(negedge clk);
    bus_if.bus_address = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_drive_lows", 32'({clk_dl, data_dl}), 32'd0);
    check("reset_status", 32'(bus_if.bus_read_data), 32'h00);
    @(negedge clk); rst_n = 1'b1;
    run_cmd(8'hF3, 0, 1'b1, 8);

    // Randomized commands, timing and resend counts
    for (int i = 0; i < 4; i++)
      run_cmd(8'($urandom), int'($urandom_range(0, 2)), 1'b1, int'($urandom_range(6, 12)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
`default_nettype wire
